// File: rtl/bk_pkg.sv
// Shared constants and state encoding for the digit-serial Brent-Kung adder.
package bk_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/bk_slice4.sv
// Combinational 4-bit Brent-Kung adder slice; carry-in folds into every prefix.
module bk_slice4
  import bk_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  logic [3:0] g, p;
  logic       g10, p10, g32, p32, g30, p30, g20, p20;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Up-sweep pairs, root, then the single down-sweep node for bit 2
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;
  assign g20 = g[2] | (p[2] & g10);
  assign p20 = p[2] & p10;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g10 | (p10 & cin);
  assign c[3] = g20 | (p20 & cin);
  assign cout = g30 | (p30 & cin);

  assign s = p ^ c;

endmodule

// File: rtl/bk_digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit Brent-Kung slice per clock, LSB digit first,
// carry held in a register between digits, valid/ready on both sides.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   RUN   | one digit per clock through the slice, cnt counts digits
//   DONE  | out_valid=1, result held until out_ready
module bk_digit_serial_adder
  import bk_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((WIDTH % DIGIT_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("bk_digit_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic                 carry_q, cout_q, ovf_q;
  logic [CW-1:0]        cnt;
  logic [DIGIT_W-1:0]   s4;
  logic                 c4;

  bk_slice4 u_slice (
    .a    (a_q[DIGIT_W-1:0]),
    .b    (b_q[DIGIT_W-1:0]),
    .cin  (carry_q),
    .s    (s4),
    .cout (c4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> DIGIT_W;
          b_q     <= b_q >> DIGIT_W;
          sum_q   <= {s4, sum_q[WIDTH-1:DIGIT_W]};
          carry_q <= c4;
          cnt     <= cnt + CW'(1);
          // On the last digit a_q/b_q hold the operand MSBs in bit 3
          if (cnt == LAST) begin
            cout_q <= c4;
            ovf_q  <= (a_q[DIGIT_W-1] == b_q[DIGIT_W-1]) && (s4[DIGIT_W-1] != a_q[DIGIT_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bk_digit_serial_adder.sv
// Self-checking bench: 16-bit vector table and corner sequences, plus a 32-bit random soak.
module tb_bk_digit_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } res32_t;

  logic clk, rst_n;

  logic        iv16, ir16, cin16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv32, ir32, cin32, ov32, or32, co32, of32;
  logic [31:0] a32, b32, s32;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t   q16[$];
  res32_t q32[$];
  vec_t   vecs[9];

  bk_digit_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
    .sum(s16), .cout(co16), .ovf(of16)
  );

  bk_digit_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(cin32), .out_valid(ov32), .out_ready(or32),
    .sum(s32), .cout(co32), .ovf(of32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  task automatic start16(input vec_t v);
    int t;
    @(negedge clk);
    a16 = v.a; b16 = v.b; cin16 = v.cin; iv16 = 1'b1;
    t = 0;
    while (!ir16 && t < 50) begin @(negedge clk); t++; end
    if (!ir16) fail("accept16");
    q16.push_back(v);
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  // k = index of the first clock edge after accept at which out_valid is present
  task automatic wait_valid16(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ov16 && k < 50);
    if (!ov16) fail("valid16");
  endtask

  task automatic check16(output vec_t v);
    if (q16.size() == 0) begin
      fail("scoreboard16_empty");
      v = '{default: '0};
    end else begin
      v = q16.pop_front();
      chk("sum16", s16, v.s);
      chk("cout16", co16, v.co);
      chk("ovf16", of16, v.ov);
      chk("in_ready_in_done", ir16, 1'b0);
    end
  endtask

  initial begin
    int k;
    vec_t v;
    logic [15:0] held;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

    rst_n = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; or16 = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; or32 = 1'b0;
    #12;
    chk("rst_in_ready", ir16, 1'b1);
    chk("rst_out_valid", ov16, 1'b0);
    chk("rst_sum", s16, 16'h0);
    chk("rst_cout", co16, 1'b0);
    chk("rst_ovf", of16, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      start16(vecs[i]);
      wait_valid16(k);
      chk("latency", k, 5);
      check16(v);
    end

    // Back-pressure: hold out_ready low for 10 cycles in DONE
    @(negedge clk);
    or16 = 1'b0;
    start16(vecs[8]);
    wait_valid16(k);
    check16(v);
    held = s16;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", ov16, 1'b1);
      chk("bp_sum_stable", s16, held);
      chk("bp_in_ready", ir16, 1'b0);
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", ov16, 1'b0);
    chk("bp_release_ready", ir16, 1'b1);

    // Reset while RUN at cnt=2
    start16(vecs[0]);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", ir16, 1'b1);
    chk("arst_out_valid", ov16, 1'b0);
    chk("arst_sum", s16, 16'h0);
    chk("arst_cout", co16, 1'b0);
    void'(q16.pop_front());
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("arst_no_valid", ov16, 1'b0);
      if (i == 1) rst_n = 1'b1;
    end
    start16(vecs[4]);
    wait_valid16(k);
    chk("post_rst_latency", k, 5);
    check16(v);
    @(negedge clk);

    // 32-bit random soak with random out_ready
    fork
      begin : producer
        int t;
        logic [32:0] full;
        res32_t r;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1)); iv32 = 1'b1;
          t = 0;
          while (!ir32 && t < 200) begin @(negedge clk); t++; end
          if (!ir32) begin fail("accept32"); break; end
          full = {1'b0, a32} + {1'b0, b32} + {32'd0, cin32};
          r.s  = full[31:0];
          r.co = full[32];
          r.ov = (a32[31] == b32[31]) && (full[31] != a32[31]);
          q32.push_back(r);
          @(posedge clk);
        end
        #1 iv32 = 1'b0;
      end
      begin : consumer
        int got, cyc;
        res32_t r;
        got = 0; cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          or32 = 1'($urandom_range(0, 1));
          if (ov32 && ir32) begin
            fail("ready_and_valid32");
          end
          if (ov32 && or32) begin
            if (q32.size() == 0) fail("scoreboard32_empty");
            else begin
              r = q32.pop_front();
              chk("result32", {co32, of32, s32}, {r.co, r.ov, r.s});
            end
            got++;
          end
        end
        if (got < 1000) fail("ops32_observed");
        or32 = 1'b0;
      end
    join
    chk("q32_empty", q32.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
